audio_sample_fifo: RTL and testbench
====================================

# audio_sample_fifo

Stereo sample buffer that sits directly upstream of the audio codec controller. It accepts left/right PCM pairs from the sample generator through a valid/ready write port. It delivers one pair per frame request from the codec controller's LRCK logic. It prefills before playback, substitutes silence on underflow, and raises a starvation flag that the controller uses to drive the codec MUTE line.

## Interface
Parameters:
- DATA_W, 16, sample width per channel (two's complement)
- DEPTH, 16, FIFO depth in stereo pairs; power of two, ≥4
- PREFILL, 8, level required to leave FILL; 1 ≤ PREFILL ≤ DEPTH
- MUTE_AFTER, 4, consecutive underflowed requests that force starvation; ≥1

Ports:
- s_CLK  in  1  system clock; all logic on rising edge
- s_NRESET  in  1  asynchronous, active-low reset
- s_EN  in  1  block enable; low flushes and idles the buffer
- i_WrValid  in  1  write pair valid
- i_WrLeft  in  DATA_W  left sample to write
- i_WrRight  in  DATA_W  right sample to write
- o_WrReady  out  1  write accepted this cycle when i_WrValid & o_WrReady
- i_SampleReq  in  1  one-cycle request for the next pair, one per LRCK frame
- o_Left  out  DATA_W  current left sample, held between requests
- o_Right  out  DATA_W  current right sample, held between requests
- o_SampleValid  out  1  one-cycle pulse: o_Left/o_Right updated
- o_Underflow  out  1  one-cycle pulse: request served with silence while in RUN
- o_Starved  out  1  level flag; request codec mute
- o_Level  out  $clog2(DEPTH)+1  stored pairs, 0..DEPTH

## Operation
- Storage: DEPTH × (2·DATA_W) array, write and read pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, and a separate level counter. Full = (level==DEPTH); empty = (level==0).
- o_WrReady = (state != IDLE) & !full, combinational from registers only, with no dependence on i_SampleReq.
- States:
  - IDLE: entered on reset or whenever s_EN=0, from any state, on the next edge. Pointers, level and starve counter are cleared, o_Left/o_Right are zeroed and o_Starved=1. Requests produce no o_SampleValid. Moves to FILL on the first edge with s_EN=1.
  - FILL: writes are accepted. Each request returns 0/0 with o_SampleValid and no pop; o_Underflow stays 0. When level ≥ PREFILL, including a level reached this cycle, the block moves to RUN on the next edge and clears o_Starved.
  - RUN: each request with level>0 pops the head pair into o_Left/o_Right and clears the starve counter. Each request with level==0 outputs 0/0, pulses o_Underflow and increments the starve counter. When the counter reaches MUTE_AFTER, the block sets o_Starved=1, clears the counter and moves to FILL.
- Simultaneous write and pop: both happen and the level is unchanged. When full, a pop does not enable the write in the same cycle, because ready is computed from the registered level.
- A write in the same cycle as a request on an empty FIFO is stored but not forwarded; the request underflows.
- Samples are passed unmodified; there is no arithmetic on data.

## Timing
- Reset values: o_Left=0, o_Right=0, o_SampleValid=0, o_Underflow=0, o_Starved=1, o_Level=0, o_WrReady=0; state=IDLE.
- Request at edge N → o_Left/o_Right/o_SampleValid/o_Underflow registered at edge N+1. Latency is 1 cycle, and back-to-back requests are each served.
- Write accepted at edge N → o_Level reflects it after edge N; poppable by a request sampled at edge N+1.
- o_Level, o_Starved and the state update together at the same edge.
- s_EN falling mid-stream → IDLE at the next edge. Any request in that cycle is dropped, and stored data is discarded.
- An asynchronous reset mid-operation forces the reset values immediately, independent of s_CLK.

## Test plan
- Reset, then s_EN=1 with no writes; issue 3 requests → three o_SampleValid pulses with 0/0, o_Underflow never 1, o_Starved=1, o_Level=0.
- Write 8 pairs (L=k, R=-k, k=1..8) → o_Level=8, then RUN with o_Starved=0. Issue 8 requests → outputs 1/-1 … 8/-8 in order, each one cycle after its request.
- Fill to DEPTH=16 → o_WrReady=0. A simultaneous request and write while full → pop succeeds, write refused, o_Level=15; the next cycle has o_WrReady=1.
- In RUN with the FIFO empty, issue 4 requests → four o_Underflow pulses with 0/0; o_Starved=1 and the state is FILL after the 4th. Refill 8 pairs → o_Starved=0.
- Write 20 pairs total while draining one pair every 3 cycles → pointer wrap-around with no loss or duplication, and the output sequence matches the input.
- Hold 5 pairs in RUN, then drop s_EN for 1 cycle → o_Level=0, o_Left=0, o_Starved=1. Assert s_NRESET low mid-stream → reset values appear asynchronously.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo PCM pair buffer feeding the codec controller
// Prefills before playback, substitutes silence on underflow, flags starvation.
module audio_sample_fifo #(
   parameter int DATA_W     = 16,
   parameter int DEPTH      = 16,
   parameter int PREFILL    = 8,
   parameter int MUTE_AFTER = 4
) (
   input  logic                       s_CLK,
   input  logic                       s_NRESET,
   input  logic                       s_EN,
   input  logic                       i_WrValid,
   input  logic [DATA_W-1:0]          i_WrLeft,
   input  logic [DATA_W-1:0]          i_WrRight,
   output logic                       o_WrReady,
   input  logic                       i_SampleReq,
   output logic [DATA_W-1:0]          o_Left,
   output logic [DATA_W-1:0]          o_Right,
   output logic                       o_SampleValid,
   output logic                       o_Underflow,
   output logic                       o_Starved,
   output logic [$clog2(DEPTH):0]     o_Level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(MUTE_AFTER + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

   state_t                state, state_nxt;
   logic [2*DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         level, level_nxt;
   logic [CW-1:0]         starve_cnt;
   logic                  full, wr_en, pop, underrun, starve_hit;

   assign full      = (level == LW'(DEPTH));
   assign o_WrReady = (state != ST_IDLE) && !full;
   assign o_Level   = level;

   always_comb begin
      wr_en      = i_WrValid && o_WrReady;
      pop        = 1'b0;
      underrun   = 1'b0;
      starve_hit = 1'b0;
      state_nxt  = state;
      if (state == ST_RUN && i_SampleReq) begin
         pop        = (level != '0);
         underrun   = (level == '0);
         starve_hit = underrun && (starve_cnt == CW'(MUTE_AFTER - 1));
      end
      level_nxt = level + LW'(wr_en) - LW'(pop);
      if (!s_EN) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_FILL;
            // the write landing this cycle counts toward the prefill threshold
            ST_FILL: if (level_nxt >= LW'(PREFILL)) state_nxt = ST_RUN;
            ST_RUN:  if (starve_hit) state_nxt = ST_FILL;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_CLK or negedge s_NRESET) begin
      if (!s_NRESET) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_ff @(posedge s_CLK) begin
      if (wr_en) mem[wr_ptr] <= {i_WrLeft, i_WrRight};
   end

   always_ff @(posedge s_CLK or negedge s_NRESET) begin
      if (!s_NRESET) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         starve_cnt    <= '0;
         o_Left        <= '0;
         o_Right       <= '0;
         o_SampleValid <= 1'b0;
         o_Underflow   <= 1'b0;
         o_Starved     <= 1'b1;
      end else if (!s_EN) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         starve_cnt    <= '0;
         o_Left        <= '0;
         o_Right       <= '0;
         o_SampleValid <= 1'b0;
         o_Underflow   <= 1'b0;
         o_Starved     <= 1'b1;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         level         <= level_nxt;
         o_Underflow   <= underrun;
         o_SampleValid <= (state != ST_IDLE) && i_SampleReq;
         if (state != ST_IDLE && i_SampleReq) begin
            // FILL and underflowed requests deliver silence
            {o_Left, o_Right} <= pop ? mem[rd_ptr] : '0;
         end
         if (pop || starve_hit) starve_cnt <= '0;
         else if (underrun)     starve_cnt <= starve_cnt + CW'(1);
         if (state == ST_FILL && state_nxt == ST_RUN) o_Starved <= 1'b0;
         if (starve_hit)                              o_Starved <= 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - randomized bench for audio_sample_fifo against a queue model
module tb_audio_sample_fifo;

   localparam int DEPTH      = 16;
   localparam int PREFILL    = 8;
   localparam int MUTE_AFTER = 4;
   localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2;

   logic        clk = 1'b0;
   logic        s_NRESET = 1'b0;
   logic        s_EN = 1'b0;
   logic        i_WrValid = 1'b0;
   logic [15:0] i_WrLeft = '0;
   logic [15:0] i_WrRight = '0;
   logic        i_SampleReq = 1'b0;
   logic        o_WrReady, o_SampleValid, o_Underflow, o_Starved;
   logic [15:0] o_Left, o_Right;
   logic [4:0]  o_Level;

   int checks = 0;
   int errors = 0;

   audio_sample_fifo #(.DATA_W(16), .DEPTH(DEPTH), .PREFILL(PREFILL), .MUTE_AFTER(MUTE_AFTER)) dut (
      .s_CLK(clk), .s_NRESET(s_NRESET), .s_EN(s_EN),
      .i_WrValid(i_WrValid), .i_WrLeft(i_WrLeft), .i_WrRight(i_WrRight), .o_WrReady(o_WrReady),
      .i_SampleReq(i_SampleReq), .o_Left(o_Left), .o_Right(o_Right),
      .o_SampleValid(o_SampleValid), .o_Underflow(o_Underflow), .o_Starved(o_Starved),
      .o_Level(o_Level)
   );

   always #5 clk = ~clk;

   wire [40:0] obs = {o_Left, o_Right, o_SampleValid, o_Underflow, o_Starved, o_Level, o_WrReady};
   localparam logic [40:0] RESET_VEC = {16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0};

   // Behavioural model: a queue of pairs plus playback mode and a miss counter.
   logic [31:0] mq[$];
   int          m_mode;
   int          m_scnt;
   logic [15:0] e_left, e_right;
   logic        e_valid, e_under, e_starved;

   function automatic void model_reset();
      mq.delete();
      m_mode = M_IDLE; m_scnt = 0;
      e_left = '0; e_right = '0; e_valid = 1'b0; e_under = 1'b0; e_starved = 1'b1;
   endfunction

   function automatic logic [40:0] exp_vec();
      logic rdy;
      rdy = (m_mode != M_IDLE) && (mq.size() < DEPTH);
      return {e_left, e_right, e_valid, e_under, e_starved, 5'(mq.size()), rdy};
   endfunction

   function automatic void model_update();
      int  was;
      bit  ready_pre;
      was       = m_mode;
      ready_pre = (m_mode != M_IDLE) && (mq.size() < DEPTH);
      e_valid = 1'b0;
      e_under = 1'b0;
      if (!s_EN) begin
         model_reset();
      end else if (was == M_IDLE) begin
         m_mode = M_FILL;
      end else begin
         if (i_SampleReq) begin
            e_valid = 1'b1; e_left = '0; e_right = '0;
            if (was == M_RUN) begin
               if (mq.size() > 0) begin
                  {e_left, e_right} = mq.pop_front();
                  m_scnt = 0;
               end else begin
                  e_under = 1'b1;
                  m_scnt++;
                  if (m_scnt == MUTE_AFTER) begin
                     e_starved = 1'b1; m_scnt = 0; m_mode = M_FILL;
                  end
               end
            end
         end
         if (i_WrValid && ready_pre) mq.push_back({i_WrLeft, i_WrRight});
         if (was == M_FILL && mq.size() >= PREFILL) begin
            m_mode = M_RUN; e_starved = 1'b0;
         end
      end
   endfunction

   task automatic step(input logic en, input logic wv, input logic [15:0] l, input logic [15:0] r,
                       input logic req);
      s_EN = en; i_WrValid = wv; i_WrLeft = l; i_WrRight = r; i_SampleReq = req;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      s_NRESET = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("FAIL reset_state got %h exp %h", obs, RESET_VEC);
      end
      #2 s_NRESET = 1'b1;
      model_reset();
   endtask

   task automatic test_fill_requests();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 1);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL fill_req_model %0d got %h exp %h", i, obs, exp_vec());
         end
         checks++;
         if ({o_SampleValid, o_Underflow, o_Starved, o_Level, o_Left, o_Right} !== {3'b101, 5'd0, 32'h0}) begin
            errors++; $display("FAIL fill_req_silence %0d got v%b u%b s%b lvl%0d", i,
                               o_SampleValid, o_Underflow, o_Starved, o_Level);
         end
      end
   endtask

   task automatic test_ordered_run();
      for (int k = 1; k <= 8; k++) begin
         step(1, 1, 16'(k), 16'(-k), 0);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL ordered_write %0d got %h exp %h", k, obs, exp_vec());
         end
      end
      checks++;
      if ({o_Level, o_Starved} !== {5'd8, 1'b0}) begin
         errors++; $display("FAIL prefill_run got lvl %0d starved %b exp 8 0", o_Level, o_Starved);
      end
      for (int k = 1; k <= 8; k++) begin
         step(1, 0, 0, 0, 1);
         checks++;
         if ({o_Left, o_Right, o_SampleValid} !== {16'(k), 16'(-k), 1'b1}) begin
            errors++; $display("FAIL ordered_pop %0d got %h/%h v%b", k, o_Left, o_Right, o_SampleValid);
         end
      end
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 1);
         checks++;
         if (obs !== exp_vec() || o_Underflow !== 1'b1) begin
            errors++; $display("FAIL underflow %0d got %h exp %h", i, obs, exp_vec());
         end
      end
      checks++;
      if (o_Starved !== 1'b1) begin
         errors++; $display("FAIL starve_flag got %b exp 1", o_Starved);
      end
      step(1, 0, 0, 0, 1);
      checks++;
      if ({o_SampleValid, o_Underflow} !== 2'b10) begin
         errors++; $display("FAIL starve_to_fill got v%b u%b exp v1 u0", o_SampleValid, o_Underflow);
      end
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 16'($urandom), 16'($urandom), 0);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL refill %0d got %h exp %h", i, obs, exp_vec());
         end
      end
      checks++;
      if (o_Starved !== 1'b0) begin
         errors++; $display("FAIL refill_unstarve got %b exp 0", o_Starved);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) step(1, 1, 16'($urandom), 16'($urandom), 0);
      checks++;
      if ({o_Level, o_WrReady} !== {5'd16, 1'b0}) begin
         errors++; $display("FAIL full_ready got lvl %0d rdy %b exp 16 0", o_Level, o_WrReady);
      end
      step(1, 1, 16'h1234, 16'h5678, 1);
      checks++;
      if ({o_Level, o_SampleValid, o_WrReady} !== {5'd15, 1'b1, 1'b1} || obs !== exp_vec()) begin
         errors++; $display("FAIL full_pop_write got %h exp %h", obs, exp_vec());
      end
      for (int i = 0; i < 15; i++) begin
         step(1, 0, 0, 0, 1);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL full_drain %0d got %h exp %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_wrap_random();
      int pushed = 0;
      logic wv;
      step(0, 0, 0, 0, 0);
      for (int c = 0; c < 150; c++) begin
         wv = (pushed < 20) && ($urandom_range(0, 3) != 0);
         if (wv && o_WrReady) pushed++;
         step(1, wv, 16'($urandom), 16'($urandom), (c % 3) == 2);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL wrap_random %0d got %h exp %h", c, obs, exp_vec());
         end
      end
      checks++;
      if (pushed != 20) begin
         errors++; $display("FAIL wrap_accepted got %0d exp 20", pushed);
      end
   endtask

   task automatic test_disable();
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 1, 16'($urandom), 16'($urandom), 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
      checks++;
      if (o_Level !== 5'd5) begin
         errors++; $display("FAIL hold_five got %0d exp 5", o_Level);
      end
      step(0, 1, 16'hAAAA, 16'h5555, 1);
      checks++;
      if ({o_Level, o_Left, o_Right, o_Starved, o_SampleValid, o_WrReady} !== {5'd0, 32'h0, 1'b1, 1'b0, 1'b0}
          || obs !== exp_vec()) begin
         errors++; $display("FAIL disable_flush got %h exp %h", obs, exp_vec());
      end
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 16'($urandom), 16'($urandom), i[0]);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL reenable %0d got %h exp %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) step(1, 1, 16'($urandom), 16'($urandom), 1);
      #2 s_NRESET = 1'b0;
      #1;
      checks++;
      if (obs !== RESET_VEC) begin
         errors++; $display("FAIL async_reset got %h exp %h", obs, RESET_VEC);
      end
      model_reset();
      #2 s_NRESET = 1'b1;
      step(1, 0, 0, 0, 0);
      step(1, 1, 16'h0101, 16'h0202, 1);
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL post_reset got %h exp %h", obs, exp_vec());
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill_requests();
      test_ordered_run();
      test_underflow();
      test_full();
      test_wrap_random();
      test_disable();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
